// File: rtl/lemmings_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lemmings_pkg
// Description : Shared state encoding and sizing helper for the lemming array.
// Revision    : 1.0 - initial release
// ============================================================================
package lemmings_pkg;

    typedef enum logic [2:0] {
        ST_WALK_L = 3'd0,
        ST_WALK_R = 3'd1,
        ST_FALL_L = 3'd2,
        ST_FALL_R = 3'd3,
        ST_DIG_L  = 3'd4,
        ST_DIG_R  = 3'd5,
        ST_SPLAT  = 3'd6
    } lem_state_e;

    // Width needed to hold 0..limit inclusive.
    function automatic int fall_cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lemming_fsm.sv
`default_nettype none
// ============================================================================
// Module      : lemming_fsm
// Description : One lemming channel: Moore state machine plus saturating
//               fall-duration counter that decides survival on landing.
// Revision    : 1.0 - initial release
// ============================================================================
module lemming_fsm
    import lemmings_pkg::*;
#(
    parameter int FALL_LIMIT = 20
) (
    input  logic clk,
    input  logic areset,
    input  logic bump_left_i,
    input  logic bump_right_i,
    input  logic ground_i,
    input  logic dig_i,
    output logic walk_left_o,
    output logic walk_right_o,
    output logic aaah_o,
    output logic digging_o,
    output logic splat_o
);

    localparam int             CNT_W    = fall_cnt_width(FALL_LIMIT);
    localparam logic [CNT_W-1:0] FALL_MAX = CNT_W'(FALL_LIMIT);

    lem_state_e       state_q, state_d;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
    logic             falling;

    assign falling = (state_q == ST_FALL_L) || (state_q == ST_FALL_R);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_WALK_L;
            fall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fall_cnt_q <= fall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WALK_L: begin
                if (!ground_i)        state_d = ST_FALL_L;
                else if (dig_i)       state_d = ST_DIG_L;
                else if (bump_left_i) state_d = ST_WALK_R;
            end
            ST_WALK_R: begin
                if (!ground_i)         state_d = ST_FALL_R;
                else if (dig_i)        state_d = ST_DIG_R;
                else if (bump_right_i) state_d = ST_WALK_L;
            end
            ST_DIG_L: if (!ground_i) state_d = ST_FALL_L;
            ST_DIG_R: if (!ground_i) state_d = ST_FALL_R;
            ST_FALL_L: begin
                if (ground_i) state_d = (fall_cnt_q >= FALL_MAX) ? ST_SPLAT : ST_WALK_L;
            end
            ST_FALL_R: begin
                if (ground_i) state_d = (fall_cnt_q >= FALL_MAX) ? ST_SPLAT : ST_WALK_R;
            end
            ST_SPLAT: state_d = ST_SPLAT;
            default:  state_d = ST_WALK_L;
        endcase
    end

    // Saturation keeps a very long fall from wrapping back to a survivable count.
    always_comb begin
        fall_cnt_d = '0;
        if (falling) begin
            fall_cnt_d = (fall_cnt_q >= FALL_MAX) ? FALL_MAX : fall_cnt_q + CNT_W'(1);
        end
    end

    assign walk_left_o  = (state_q == ST_WALK_L);
    assign walk_right_o = (state_q == ST_WALK_R);
    assign aaah_o       = falling;
    assign digging_o    = (state_q == ST_DIG_L) || (state_q == ST_DIG_R);
    assign splat_o      = (state_q == ST_SPLAT);

endmodule
`default_nettype wire

// File: rtl/lemmings_splat_array.sv
`default_nettype none
// ============================================================================
// Module      : lemmings_splat_array
// Description : NUM_LEM independent lemming channels with a live-population
//               count for the scoreboard logic above.
// Revision    : 1.0 - initial release
// ============================================================================
module lemmings_splat_array
    import lemmings_pkg::*;
#(
    parameter int NUM_LEM    = 1,
    parameter int FALL_LIMIT = 20
) (
    input  logic                             clk,
    input  logic                             areset,
    input  logic [NUM_LEM-1:0]               bump_left,
    input  logic [NUM_LEM-1:0]               bump_right,
    input  logic [NUM_LEM-1:0]               ground,
    input  logic [NUM_LEM-1:0]               dig,
    output logic [NUM_LEM-1:0]               walk_left,
    output logic [NUM_LEM-1:0]               walk_right,
    output logic [NUM_LEM-1:0]               aaah,
    output logic [NUM_LEM-1:0]               digging,
    output logic [NUM_LEM-1:0]               splat,
    output logic [$clog2(NUM_LEM+1)-1:0]     alive_cnt
);

    localparam int ALIVE_W = $clog2(NUM_LEM + 1);

    logic [NUM_LEM-1:0] alive;

    for (genvar g = 0; g < NUM_LEM; g++) begin : g_lem
        lemming_fsm #(
            .FALL_LIMIT(FALL_LIMIT)
        ) u_fsm (
            .clk         (clk),
            .areset      (areset),
            .bump_left_i (bump_left[g]),
            .bump_right_i(bump_right[g]),
            .ground_i    (ground[g]),
            .dig_i       (dig[g]),
            .walk_left_o (walk_left[g]),
            .walk_right_o(walk_right[g]),
            .aaah_o      (aaah[g]),
            .digging_o   (digging[g]),
            .splat_o     (splat[g])
        );
    end

    assign alive = ~splat;

    always_comb begin
        alive_cnt = '0;
        for (int i = 0; i < NUM_LEM; i++) begin
            alive_cnt = alive_cnt + ALIVE_W'(alive[i]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lemmings_splat_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_lemmings_splat_array
// Description : Directed vector bench for a 3-channel array, fall limit 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lemmings_splat_array;

    localparam int NUM_LEM    = 3;
    localparam int FALL_LIMIT = 4;

    logic       clk;
    logic       areset;
    logic [2:0] bump_left, bump_right, ground, dig;
    logic [2:0] walk_left, walk_right, aaah, digging, splat;
    logic [1:0] alive_cnt;

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic [2:0] bl, br, gnd, dg;
        logic [2:0] wl, wr, aa, dgo, sp;
        logic [1:0] al;
    } vec_t;

    vec_t tbl [18];

    lemmings_splat_array #(
        .NUM_LEM   (NUM_LEM),
        .FALL_LIMIT(FALL_LIMIT)
    ) u_dut (
        .clk       (clk),
        .areset    (areset),
        .bump_left (bump_left),
        .bump_right(bump_right),
        .ground    (ground),
        .dig       (dig),
        .walk_left (walk_left),
        .walk_right(walk_right),
        .aaah      (aaah),
        .digging   (digging),
        .splat     (splat),
        .alive_cnt (alive_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] wl, input logic [2:0] wr,
                         input logic [2:0] aa, input logic [2:0] dg, input logic [2:0] sp,
                         input logic [1:0] al);
        n_cmp++;
        if ({walk_left, walk_right, aaah, digging, splat, alive_cnt} !== {wl, wr, aa, dg, sp, al}) begin
            n_err++;
            $display("FAIL %s: got wl=%b wr=%b aaah=%b dig=%b splat=%b alive=%0d, expected wl=%b wr=%b aaah=%b dig=%b splat=%b alive=%0d",
                     name, walk_left, walk_right, aaah, digging, splat, alive_cnt,
                     wl, wr, aa, dg, sp, al);
        end
    endtask

    // Drive inputs just after an edge, then settle just after the next one.
    task automatic step(input logic [2:0] bl, input logic [2:0] br,
                        input logic [2:0] gnd, input logic [2:0] dg);
        bump_left  = bl;
        bump_right = br;
        ground     = gnd;
        dig        = dg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        //            bl      br      gnd     dg      wl      wr      aa      dgo     sp      al
        tbl[0]  = '{3'b001, 3'b000, 3'b111, 3'b000, 3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 2'd3};
        tbl[1]  = '{3'b000, 3'b001, 3'b111, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 2'd3};
        tbl[2]  = '{3'b011, 3'b011, 3'b111, 3'b000, 3'b100, 3'b011, 3'b000, 3'b000, 3'b000, 2'd3};
        tbl[3]  = '{3'b011, 3'b011, 3'b111, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 2'd3};
        tbl[4]  = '{3'b001, 3'b000, 3'b111, 3'b000, 3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 2'd3};
        tbl[5]  = '{3'b000, 3'b000, 3'b111, 3'b001, 3'b110, 3'b000, 3'b000, 3'b001, 3'b000, 2'd3};
        tbl[6]  = '{3'b001, 3'b001, 3'b111, 3'b001, 3'b110, 3'b000, 3'b000, 3'b001, 3'b000, 2'd3};
        tbl[7]  = '{3'b000, 3'b000, 3'b110, 3'b001, 3'b110, 3'b000, 3'b001, 3'b000, 3'b000, 2'd3};
        tbl[8]  = '{3'b000, 3'b000, 3'b110, 3'b001, 3'b110, 3'b000, 3'b001, 3'b000, 3'b000, 2'd3};
        tbl[9]  = '{3'b000, 3'b000, 3'b110, 3'b001, 3'b110, 3'b000, 3'b001, 3'b000, 3'b000, 2'd3};
        tbl[10] = '{3'b000, 3'b000, 3'b111, 3'b001, 3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 2'd3};
        tbl[11] = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 2'd3};
        tbl[12] = '{3'b010, 3'b000, 3'b101, 3'b010, 3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 2'd3};
        tbl[13] = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 2'd3};
        tbl[14] = '{3'b010, 3'b000, 3'b111, 3'b010, 3'b100, 3'b001, 3'b000, 3'b010, 3'b000, 2'd3};
        tbl[15] = '{3'b010, 3'b000, 3'b111, 3'b000, 3'b100, 3'b001, 3'b000, 3'b010, 3'b000, 2'd3};
        tbl[16] = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 2'd3};
        tbl[17] = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 2'd3};

        areset     = 1'b1;
        bump_left  = '0;
        bump_right = '0;
        ground     = '1;
        dig        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 2'd3);
        areset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].bl, tbl[i].br, tbl[i].gnd, tbl[i].dg);
            check($sformatf("vec%0d", i), tbl[i].wl, tbl[i].wr, tbl[i].aa, tbl[i].dgo, tbl[i].sp, tbl[i].al);
        end

        // Lemming 1 falls exactly the limit and survives.
        for (int i = 0; i < FALL_LIMIT; i++) begin
            step(3'b000, 3'b000, 3'b101, 3'b000);
            check($sformatf("fall4_c%0d", i), 3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 2'd3);
        end
        step(3'b000, 3'b000, 3'b111, 3'b000);
        check("land_fall4", 3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 2'd3);

        // One cycle longer splats it.
        for (int i = 0; i < FALL_LIMIT + 1; i++) step(3'b000, 3'b000, 3'b101, 3'b000);
        step(3'b000, 3'b000, 3'b111, 3'b000);
        check("land_fall5", 3'b100, 3'b001, 3'b000, 3'b000, 3'b010, 2'd2);

        for (int i = 0; i < 10; i++) begin
            logic [2:0] pat;
            pat = 3'(i);
            step({1'b0, pat[0], 1'b0}, {1'b0, pat[1], 1'b0},
                 {1'b1, pat[1], 1'b1}, {1'b0, pat[0] ^ pat[2], 1'b0});
            check($sformatf("splat_hold%0d", i), 3'b100, 3'b001, 3'b000, 3'b000, 3'b010, 2'd2);
        end

        step(3'b100, 3'b000, 3'b111, 3'b000);
        check("ch2_bump", 3'b000, 3'b101, 3'b000, 3'b000, 3'b010, 2'd2);
        step(3'b000, 3'b001, 3'b111, 3'b000);
        check("ch0_bump", 3'b001, 3'b100, 3'b000, 3'b000, 3'b010, 2'd2);

        // 41 cycles would wrap a 3-bit counter to 0 without saturation.
        step(3'b000, 3'b000, 3'b110, 3'b000);
        check("long_fall_start", 3'b000, 3'b100, 3'b001, 3'b000, 3'b010, 2'd2);
        for (int i = 1; i < 41; i++) step(3'b000, 3'b000, 3'b110, 3'b000);
        step(3'b000, 3'b000, 3'b111, 3'b000);
        check("long_fall_land", 3'b000, 3'b100, 3'b000, 3'b000, 3'b011, 2'd1);

        step(3'b000, 3'b000, 3'b011, 3'b000);
        check("ch2_fall", 3'b000, 3'b000, 3'b100, 3'b000, 3'b011, 2'd1);

        // Asynchronous reset mid-cycle, observed before the next edge.
        #2 areset = 1'b1;
        #1;
        check("async_reset", 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 2'd3);
        ground = 3'b111;
        #2 areset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset", 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 2'd3);
        step(3'b001, 3'b000, 3'b111, 3'b000);
        check("post_reset_bump", 3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
